// File: rtl/sub_40b_seq_if.sv
// -----------------------------------------------------------------------------
// sub_40b_seq_if
// Handshake and data bundle for the sequential 40-bit subtractor.
//   start  : request, sampled by the subtractor only while idle
//   A, B   : 40-bit minuend / subtrahend, captured on the accepting edge
//   Bin    : borrow-in, captured on the accepting edge
//   busy   : high while chunks are being processed
//   done   : one-cycle pulse when D/Bout/V are final
//   D      : 40-bit difference (registered)
//   Bout   : borrow out of bit 39
//   V      : two's-complement overflow
// master = requester side, slave = subtractor side.
// -----------------------------------------------------------------------------
interface sub_40b_seq_if;
    logic        start;
    logic [39:0] A;
    logic [39:0] B;
    logic        Bin;
    logic        busy;
    logic        done;
    logic [39:0] D;
    logic        Bout;
    logic        V;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout, V
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout, V
    );
endinterface

// File: rtl/sub_40b_seq.sv
// -----------------------------------------------------------------------------
// sub_40b_seq
// Sequential 40-bit ripple-borrow subtractor: D = A - B - Bin, computed one
// SLICE-bit chunk per clock, LSB chunk first, with a registered borrow carried
// between chunks. N = 40/SLICE chunk cycles; one operation every N+2 cycles.
//
// Parameters:
//   SLICE   : bits per cycle, one of 1, 2, 4, 5, 8, 10, 20, 40 (default 8)
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (release synchronized internally)
//   bus     : sub_40b_seq_if.slave (start/A/B/Bin in, busy/done/D/Bout/V out)
// Configuration macro:
//   SUB40_OVF_EN : when defined, the signed overflow flag V is generated;
//                  otherwise V is tied to 0.
// -----------------------------------------------------------------------------
module sub_40b_seq #(
    parameter int SLICE = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    sub_40b_seq_if.slave  bus
);

    localparam int N  = 40 / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [39:0]       a_q, a_d;
    logic [39:0]       b_q, b_d;
    logic [39:0]       dres_q, dres_d;
    logic              brw_q, brw_d;
    logic              bout_q, bout_d;
    logic [KW-1:0]     k_q, k_d;
    logic [1:0]        sync_q;

    logic              rdy;
    logic [5:0]        base;
    logic [SLICE-1:0]  a_chunk;
    logic [SLICE-1:0]  b_chunk;
    logic [SLICE:0]    chunk_diff;
    logic              last_chunk;

    // Reset release is re-timed through two flops so that a start coinciding
    // with an asynchronous deassertion is never half-accepted.
    assign rdy = sync_q[1];

    assign base       = 6'(int'(k_q) * SLICE);
    assign a_chunk    = a_q[base +: SLICE];
    assign b_chunk    = b_q[base +: SLICE];
    // The extra MSB of the widened difference is the borrow out of this chunk.
    assign chunk_diff = {1'b0, a_chunk} - {1'b0, b_chunk} - {{SLICE{1'b0}}, brw_q};
    assign last_chunk = (state_q == RUN) && (k_q == KW'(N - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dres_d  = dres_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (bus.start && rdy) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    brw_d   = bus.Bin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                dres_d[base +: SLICE] = chunk_diff[SLICE-1:0];
                brw_d                 = chunk_diff[SLICE];
                if (last_chunk) begin
                    bout_d  = chunk_diff[SLICE];
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dres_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            k_q     <= '0;
            sync_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dres_q  <= dres_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            k_q     <= k_d;
            sync_q  <= {sync_q[0], 1'b1};
        end
    end

`ifdef SUB40_OVF_EN
    // Overflow: operands of opposite sign and the result sign differs from
    // the minuend. The result sign is the MSB of the final chunk.
    logic v_q, v_d;

    always_comb begin
        v_d = v_q;
        if (last_chunk) begin
            v_d = (a_q[39] ^ b_q[39]) & (chunk_diff[SLICE-1] ^ a_q[39]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

    assign bus.V = v_q;
`else
    assign bus.V = 1'b0;
`endif

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.D    = dres_q;
    assign bus.Bout = bout_q;

endmodule

// File: tb/tb_sub_40b_seq.sv
// -----------------------------------------------------------------------------
// tb_sub_40b_seq
// Drives three subtractor instances (SLICE = 8, 4, 40) with identical
// stimulus and compares each against a 41-bit arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_sub_40b_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st;
    logic [39:0] a_in, b_in;
    logic        bin_in;

    always #5 clk = ~clk;

    sub_40b_seq_if if8 ();
    sub_40b_seq_if if4 ();
    sub_40b_seq_if if40 ();

    assign if8.start  = st;   assign if8.A  = a_in; assign if8.B  = b_in; assign if8.Bin  = bin_in;
    assign if4.start  = st;   assign if4.A  = a_in; assign if4.B  = b_in; assign if4.Bin  = bin_in;
    assign if40.start = st;   assign if40.A = a_in; assign if40.B = b_in; assign if40.Bin = bin_in;

    sub_40b_seq #(.SLICE(8))  u_s8  (.clk(clk), .reset_n(rst_n), .bus(if8.slave));
    sub_40b_seq #(.SLICE(4))  u_s4  (.clk(clk), .reset_n(rst_n), .bus(if4.slave));
    sub_40b_seq #(.SLICE(40)) u_s40 (.clk(clk), .reset_n(rst_n), .bus(if40.slave));

    logic        busy_w [3];
    logic        done_w [3];
    logic        bout_w [3];
    logic        v_w    [3];
    logic [39:0] d_w    [3];

    assign busy_w[0] = if8.busy;  assign done_w[0] = if8.done;  assign d_w[0] = if8.D;  assign bout_w[0] = if8.Bout;  assign v_w[0] = if8.V;
    assign busy_w[1] = if4.busy;  assign done_w[1] = if4.done;  assign d_w[1] = if4.D;  assign bout_w[1] = if4.Bout;  assign v_w[1] = if4.V;
    assign busy_w[2] = if40.busy; assign done_w[2] = if40.done; assign d_w[2] = if40.D; assign bout_w[2] = if40.Bout; assign v_w[2] = if40.V;

    int n_chk  = 0;
    int n_fail = 0;

    int          lat_r  [3];
    int          dcnt_r [3];
    logic [41:0] res_r  [3];
    int          lat_exp  [3] = '{5, 10, 1};
    int          slice_of [3] = '{8, 4, 40};

`ifdef SUB40_OVF_EN
    localparam logic VOVF = 1'b1;
`else
    localparam logic VOVF = 1'b0;
`endif

    // Reference: full-width unsigned subtraction; bit 40 is the borrow.
    function automatic logic [41:0] ref_sub(input logic [39:0] a, input logic [39:0] b,
                                            input logic bi);
        logic [40:0] t;
        logic        v;
        t = {1'b0, a} - {1'b0, b} - {40'd0, bi};
        v = VOVF & (a[39] != b[39]) & (t[39] != a[39]);
        return {v, t[40], t[39:0]};
    endfunction

    // Presents an operation and returns 1 ns after the accepting edge, with
    // the inputs already scrambled so the captured copy is what counts.
    task automatic start_op(input logic [39:0] a, input logic [39:0] b, input logic bi);
        @(negedge clk);
        st = 1'b1; a_in = a; b_in = b; bin_in = bi;
        @(posedge clk);
        #1;
        st = 1'b0;
        a_in = {8'($urandom), $urandom()};
        b_in = ~b;
        bin_in = ~bi;
    endtask

    // Watches a fixed window after the accept; records the first done cycle,
    // the number of done cycles and the outputs seen at the first done.
    task automatic wait_done(input int budget);
        for (int i = 0; i < 3; i++) begin
            lat_r[i] = 0; dcnt_r[i] = 0; res_r[i] = '0;
        end
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (done_w[i]) begin
                    dcnt_r[i]++;
                    if (lat_r[i] == 0) begin
                        lat_r[i] = c;
                        res_r[i] = {v_w[i], bout_w[i], d_w[i]};
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({busy_w[i], done_w[i], d_w[i], bout_w[i], v_w[i]} !== 43'd0) begin
                n_fail++;
                $display("FAIL reset_state slice%0d: got busy=%b done=%b D=%h Bout=%b V=%b, want all 0",
                         slice_of[i], busy_w[i], done_w[i], d_w[i], bout_w[i], v_w[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({busy_w[i], done_w[i]} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_after_reset slice%0d: got busy=%b done=%b, want 0 0",
                         slice_of[i], busy_w[i], done_w[i]);
            end
        end
    endtask

    task automatic test_vectors();
        logic [39:0] va [4] = '{40'h00_0000_0000, 40'h00_0000_0000, 40'h80_0000_0000, 40'hAA_AAAA_AAAA};
        logic [39:0] vb [4] = '{40'h00_0000_0000, 40'h00_0000_0001, 40'h00_0000_0001, 40'h55_5555_5555};
        logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [41:0] ve [4] = '{{1'b0, 1'b0, 40'h00_0000_0000},
                                {1'b0, 1'b1, 40'hFF_FFFF_FFFF},
                                {VOVF, 1'b0, 40'h7F_FFFF_FFFF},
                                {VOVF, 1'b0, 40'h55_5555_5554}};
        logic [39:0] a, b;
        logic        bi;
        logic [41:0] exp;
        for (int n = 0; n < 20; n++) begin
            if (n < 4) begin
                a = va[n]; b = vb[n]; bi = vc[n]; exp = ve[n];
            end else begin
                a  = {8'($urandom), $urandom()};
                b  = (n % 5 == 0) ? a : {8'($urandom), $urandom()};
                bi = 1'($urandom);
                exp = ref_sub(a, b, bi);
            end
            start_op(a, b, bi);
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (busy_w[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_after_accept op%0d slice%0d: got %b want 1", n, slice_of[i], busy_w[i]);
                end
            end
            wait_done(14);
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (lat_r[i] !== lat_exp[i]) begin
                    n_fail++;
                    $display("FAIL done_latency op%0d slice%0d: got %0d want %0d", n, slice_of[i], lat_r[i], lat_exp[i]);
                end
                n_chk++;
                if (dcnt_r[i] !== 1) begin
                    n_fail++;
                    $display("FAIL done_width op%0d slice%0d: got %0d cycles want 1", n, slice_of[i], dcnt_r[i]);
                end
                n_chk++;
                if (res_r[i] !== exp) begin
                    n_fail++;
                    $display("FAIL result op%0d slice%0d A=%h B=%h Bin=%b: got V=%b Bout=%b D=%h want V=%b Bout=%b D=%h",
                             n, slice_of[i], a, b, bi, res_r[i][41], res_r[i][40], res_r[i][39:0],
                             exp[41], exp[40], exp[39:0]);
                end
            end
        end
    endtask

    // start held high and operands changed during RUN; checked on SLICE=8.
    task automatic test_hold_start();
        logic [41:0] exp1, exp2, got;
        int          lat2;
        exp1 = {VOVF, 1'b0, 40'h55_5555_5554};
        exp2 = ref_sub(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1);
        @(negedge clk);
        st = 1'b1; a_in = 40'hAA_AAAA_AAAA; b_in = 40'h55_5555_5555; bin_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in = 40'hFF_FFFF_FFFF; b_in = 40'hFF_FFFF_FFFF;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) begin
                got = {v_w[0], bout_w[0], d_w[0]};
                n_chk++;
                if (done_w[0] !== 1'b1 || got !== exp1) begin
                    n_fail++;
                    $display("FAIL hold_start_result: got done=%b V=%b Bout=%b D=%h want done=1 V=%b Bout=0 D=%h",
                             done_w[0], got[41], got[40], got[39:0], exp1[41], exp1[39:0]);
                end
            end
            if (c == 6) begin
                n_chk++;
                if ({busy_w[0], done_w[0]} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL hold_start_idle: got busy=%b done=%b want 0 0", busy_w[0], done_w[0]);
                end
            end
            if (c == 7) begin
                n_chk++;
                if (busy_w[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hold_start_reaccept: got busy=%b want 1", busy_w[0]);
                end
            end
        end
        @(negedge clk);
        st = 1'b0;
        lat2 = 0; got = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (done_w[0] && lat2 == 0) begin
                lat2 = c;
                got  = {v_w[0], bout_w[0], d_w[0]};
            end
        end
        n_chk++;
        if (lat2 == 0 || got !== exp2) begin
            n_fail++;
            $display("FAIL hold_start_second_op: got seen=%0d V=%b Bout=%b D=%h want V=%b Bout=%b D=%h",
                     lat2, got[41], got[40], got[39:0], exp2[41], exp2[40], exp2[39:0]);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic        saw;
        logic [41:0] exp;
        start_op({8'($urandom), $urandom()}, {8'($urandom), $urandom()}, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({busy_w[i], done_w[i], d_w[i], bout_w[i], v_w[i]} !== 43'd0) begin
                n_fail++;
                $display("FAIL abort_outputs slice%0d: got busy=%b done=%b D=%h Bout=%b V=%b, want all 0",
                         slice_of[i], busy_w[i], done_w[i], d_w[i], bout_w[i], v_w[i]);
            end
        end
        #1;
        rst_n = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (done_w[i] || busy_w[i]) saw = 1'b1;
            end
        end
        n_chk++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got activity=%b after abort want 0", saw);
        end
        exp = {1'b0, 1'b0, 40'h00_0000_0007};
        start_op(40'd10, 40'd3, 1'b0);
        wait_done(14);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (lat_r[i] !== lat_exp[i] || res_r[i] !== exp) begin
                n_fail++;
                $display("FAIL after_abort_op slice%0d: got lat=%0d D=%h Bout=%b V=%b want lat=%0d D=%h Bout=0 V=0",
                         slice_of[i], lat_r[i], res_r[i][39:0], res_r[i][40], res_r[i][41],
                         lat_exp[i], exp[39:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold_start();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
